// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
//   Bank of NFLAG set/reset flags that NREQ requesters write through a round-robin
//   arbiter. One command is granted per clock, and the winning command updates the bank
//   on the same edge that raises its grant.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_all    : synchronous clear of the whole bank; overrides any grant
//   req        : per-requester request, held until granted
//   cmd_s/r    : per-requester set/reset bits; set dominates
//   cmd_idx    : flat index bus, requester i at [i*IDXW +: IDXW]
//   gnt        : registered one-hot grant pulse
//   gnt_id     : binary id of the last grant
//   idx_err    : pulse alongside gnt when the granted index is out of range
//   q, qbar    : flag state and its complement
module sr_flag_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_all,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          cmd_s,
  input  logic [NREQ-1:0]          cmd_r,
  input  logic [NREQ*IDXW-1:0]     cmd_idx,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     idx_err,
  output logic [NFLAG-1:0]         q,
  output logic [NFLAG-1:0]         qbar
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = IDW + 1;

  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic [IDW-1:0]   r_ptr;
  logic             r_idx_err;
  logic [NFLAG-1:0] r_q;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [SW-1:0]    w_sum;
  logic [IDW-1:0]   w_cand;
  logic [NREQ-1:0]  w_onehot;
  logic [IDXW-1:0]  w_idx;
  logic             w_s;
  logic             w_r;
  logic             w_oob;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [NFLAG-1:0] w_q_nxt;

  // A requester granted last cycle sits out one cycle so a held req is a fresh request.
  assign w_elig = req & ~r_gnt;

  // Rotating scan starting at the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_sum = {1'b0, r_ptr} + SW'(off);
      if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
      w_cand = w_sum[IDW-1:0];
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Winner's command fields, selected with constant slices.
  always_comb begin
    w_onehot = '0;
    w_idx    = '0;
    w_s      = 1'b0;
    w_r      = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_win) begin
        w_onehot[i] = 1'b1;
        w_idx       = cmd_idx[i*IDXW +: IDXW];
        w_s         = cmd_s[i];
        w_r         = cmd_r[i];
      end
    end
  end

  assign w_oob     = (32'(w_idx) >= NFLAG);
  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  always_comb begin
    w_q_nxt = r_q;
    for (int unsigned k = 0; k < NFLAG; k++) begin
      if (!w_oob && (32'(w_idx) == k)) begin
        if (w_s)      w_q_nxt[k] = 1'b1;
        else if (w_r) w_q_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_idx_err <= 1'b0;
      r_q       <= '0;
    end else if (clr_all) begin
      // Pointer is left alone so pending requesters keep their turn order.
      r_gnt     <= '0;
      r_idx_err <= 1'b0;
      r_q       <= '0;
    end else if (w_found) begin
      r_gnt     <= w_onehot;
      r_gnt_id  <= w_win;
      r_ptr     <= w_ptr_nxt;
      r_idx_err <= w_oob;
      r_q       <= w_q_nxt;
    end else begin
      r_gnt     <= '0;
      r_idx_err <= 1'b0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign idx_err = r_idx_err;
  assign q       = r_q;
  assign qbar    = ~r_q;

endmodule
